// File: rtl/fifo_sync_flags_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_flags_if
//  Purpose  : Bundle of the producer/consumer signals of fifo_sync_flags.
//             master = the side driving writes, reads and flush,
//             slave  = the FIFO itself.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_sync_flags_if #(
    parameter int W = 32,
    parameter int D = 8
) ();
    localparam int CW = $clog2(D + 1);

    logic          in_clr;
    logic [W-1:0]  in_data;
    logic          in_w_en;
    logic          in_r_en;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          o_full;
    logic          o_empty;
    logic          o_afull;
    logic          o_aempty;
    logic [CW-1:0] o_count;
    logic          o_ovf;
    logic          o_udf;

    modport master (
        output in_clr, in_data, in_w_en, in_r_en,
        input  o_data, o_valid, o_full, o_empty, o_afull, o_aempty,
               o_count, o_ovf, o_udf
    );

    modport slave (
        input  in_clr, in_data, in_w_en, in_r_en,
        output o_data, o_valid, o_full, o_empty, o_afull, o_aempty,
               o_count, o_ovf, o_udf
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_flags
//  Purpose  : Single-clock FIFO of any depth D (all D entries usable) with
//             occupancy count, almost-full/almost-empty thresholds, sticky
//             overflow/underflow flags and a synchronous flush.
//  Config   : FIFO_FWFT_EN defined   -> first-word-fall-through read port
//             FIFO_FWFT_EN undefined -> registered (standard) read port
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync_flags #(
    parameter int W      = 32,
    parameter int D      = 8,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  wire logic          in_clk,
    input  wire logic          in_rst_n,
    fifo_sync_flags_if.slave   bus
);
    localparam int            CW     = $clog2(D + 1);
    localparam int            PW     = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] C_D    = CW'(D);
    localparam logic [CW-1:0] C_AF   = CW'(AF_LVL);
    localparam logic [CW-1:0] C_AE   = CW'(AE_LVL);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [PW-1:0] C_PMAX = PW'(D - 1);
    localparam logic [PW-1:0] C_PONE = PW'(1);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_rd_pop;
    logic          w_wr_push;

    // Flags are pure decodes of the registered occupancy.
    assign w_full   = (count_q == C_D);
    assign w_empty  = (count_q == '0);

    // A read needs a stored word; a write on full rides on a same-cycle read.
    assign w_rd_ok   = bus.in_r_en & ~w_empty;
    assign w_wr_ok   = bus.in_w_en & (~w_full | w_rd_ok);
    // Flush wins over any transfer in the same cycle.
    assign w_rd_pop  = w_rd_ok & ~bus.in_clr;
    assign w_wr_push = w_wr_ok & ~bus.in_clr;

    assign bus.o_full   = w_full;
    assign bus.o_empty  = w_empty;
    assign bus.o_afull  = (count_q >= C_AF);
    assign bus.o_aempty = (count_q <= C_AE);
    assign bus.o_count  = count_q;
    assign bus.o_ovf    = ovf_q;
    assign bus.o_udf    = udf_q;

    // Next-state for pointers (explicit wrap at D-1), count and error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (bus.in_w_en & ~w_wr_ok);
        udf_d    = udf_q | (bus.in_r_en & ~w_rd_ok);
        if (bus.in_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (w_wr_push) begin
                wr_ptr_d = (wr_ptr_q == C_PMAX) ? '0 : wr_ptr_q + C_PONE;
            end
            if (w_rd_pop) begin
                rd_ptr_d = (rd_ptr_q == C_PMAX) ? '0 : rd_ptr_q + C_PONE;
            end
            if (w_wr_push && !w_rd_pop) begin
                count_d = count_q + C_ONE;
            end else if (w_rd_pop && !w_wr_push) begin
                count_d = count_q - C_ONE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge in_clk) begin
        if (w_wr_push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is shown directly; a read acknowledges and pops it.
    assign bus.o_data  = mem_q[rd_ptr_q];
    assign bus.o_valid = ~w_empty;
`else
    logic [W-1:0] data_q;
    logic         valid_q;

    // Registered read port: data lands at the edge, valid pulses one cycle.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= w_rd_pop;
            if (w_rd_pop) begin
                data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
`endif

endmodule
`default_nettype wire
